// File: rtl/ppi_pkg.sv
// Shared constants for the PPI port C handshake block: control-word fields, modes, pin map.
// Latency: none (declarations only).
// Backpressure: none.
package ppi_pkg;

   // Control-word field positions.
   localparam int CW_MSET     = 7;
   localparam int CW_AMODE_HI = 6;
   localparam int CW_AMODE_LO = 5;
   localparam int CW_DIRA     = 4;
   localparam int CW_DIRCU    = 3;
   localparam int CW_BMODE    = 2;
   localparam int CW_DIRB     = 1;
   localparam int CW_DIRCL    = 0;
   localparam int CW_BSR_HI   = 3;
   localparam int CW_BSR_LO   = 1;
   localparam int CW_BSR_VAL  = 0;

   // Group mode encodings; group A's 1x codes collapse onto MODE1.
   typedef enum logic [1:0] {
      MODE0 = 2'b00,
      MODE1 = 2'b01
   } mode_e;

   // Mode-1 pin indices on PC[7:0].
   localparam int PC_INTR_A = 3;
   localparam int PC_STB_A  = 4;
   localparam int PC_IBF_A  = 5;
   localparam int PC_ACK_A  = 6;
   localparam int PC_OBF_A  = 7;
   localparam int PC_INTR_B = 0;
   localparam int PC_HS1_B  = 1;
   localparam int PC_HS2_B  = 2;

   // Mode word after reset: all ports input, both groups mode 0.
   localparam logic [7:0] MODE_RST = 8'h9B;

   // Decoded view of the stored mode word (bit 7 is not stored).
   typedef struct packed {
      logic a_m1;
      logic dir_a;
      logic dir_cu;
      logic b_m1;
      logic dir_b;
      logic dir_cl;
   } mode_t;

   function automatic mode_e grp_a_mode(input logic [6:0] w);
      return (w[CW_AMODE_HI:CW_AMODE_LO] == 2'b00) ? MODE0 : MODE1;
   endfunction

   function automatic mode_t mode_decode(input logic [6:0] w);
      mode_t m;
      m.a_m1   = (grp_a_mode(w) == MODE1);
      m.dir_a  = w[CW_DIRA];
      m.dir_cu = w[CW_DIRCU];
      m.b_m1   = w[CW_BMODE];
      m.dir_b  = w[CW_DIRB];
      m.dir_cl = w[CW_DIRCL];
      return m;
   endfunction

endpackage

// File: rtl/ppi_hs_chan.sv
// One mode-1 handshake channel: strobe synchroniser, edge detect, IBF/OBF_n/INTE/INTR flags.
// Latency: pad edge -> fall/rise pulse SYNC_STAGES+1 cycles; flags update one cycle after the pulse.
// Backpressure: none; rd/wr/strobe events are single-cycle and never stalled.
module ppi_hs_chan #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic Reset,
   input  logic clr,        // mode-set write: return flags to idle
   input  logic en,         // group is in mode 1
   input  logic dir,        // 1 = input handshake (STB/IBF), 0 = output (ACK/OBF_n)
   input  logic stb_pad,    // STB_n or ACK_n pad value
   input  logic rd,
   input  logic wr,
   input  logic inte_wr,
   input  logic inte_val,
   output logic ibf,
   output logic obf_n,
   output logic inte,
   output logic intr,
   output logic latch,
   output logic stb_rdata   // value returned on a port C read of the strobe pin
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   last_q;
   logic                   fall_q;
   logic                   rise_q;
   logic                   stb_s;

   assign stb_s = sync_q[SYNC_STAGES-1];

   // Synchronise the strobe (idle high) and register its fall/rise edges.
   always_ff @(posedge clk) begin
      if (Reset) begin
         sync_q <= '1;
         last_q <= 1'b1;
         fall_q <= 1'b0;
         rise_q <= 1'b0;
      end else begin
         sync_q[0] <= stb_pad;
         for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_q[i] <= sync_q[i-1];
         end
         last_q <= stb_s;
         fall_q <= last_q & ~stb_s;
         rise_q <= ~last_q & stb_s;
      end
   end

   // Handshake flags; set conditions win over a coincident CPU read, CPU write wins over ACK.
   always_ff @(posedge clk) begin
      if (Reset || clr) begin
         ibf   <= 1'b0;
         obf_n <= 1'b1;
         inte  <= 1'b0;
         intr  <= 1'b0;
      end else begin
         if (inte_wr) begin
            inte <= inte_val;
         end
         if (en && dir) begin
            if (fall_q) begin
               ibf <= 1'b1;
            end else if (rd) begin
               ibf <= 1'b0;
            end
            if (rise_q && inte && ibf) begin
               intr <= 1'b1;
            end else if (rd) begin
               intr <= 1'b0;
            end
         end else if (en) begin
            if (wr) begin
               obf_n <= 1'b0;
            end else if (fall_q) begin
               obf_n <= 1'b1;
            end
            if (wr) begin
               intr <= 1'b0;
            end else if (rise_q && inte && obf_n) begin
               intr <= 1'b1;
            end
         end
      end
   end

   // Input register capture coincides with the STB fall pulse.
   assign latch = en & dir & fall_q;

`ifdef PPI_PORTC_STATUS_EN
   assign stb_rdata = inte;
`else
   assign stb_rdata = stb_pad;
`endif

endmodule

// File: rtl/ppi_portc_hs.sv
// 8255-style port C owner: BSR latch, mode register, mode-1 handshakes for groups A/B (PPI_PORTC_STATUS_EN selects status-word reads).
// Latency: control words and CPU strobes take effect the next cycle; pad strobes after SYNC_STAGES+1 cycles plus one.
// Backpressure: none; all inputs are single-cycle strobes accepted unconditionally.
module ppi_portc_hs #(
   parameter int         SYNC_STAGES = 2,
   parameter logic [7:0] PC_RST      = 8'h00
) (
   input  logic       clk,
   input  logic       Reset,
   input  logic       cw_wr,
   input  logic [7:0] cw_data,
   input  logic       rd_a,
   input  logic       rd_b,
   input  logic       wr_a,
   input  logic       wr_b,
   input  logic [7:0] pc_in,
   output logic [7:0] pc_out,
   output logic [7:0] pc_oe,
   output logic [7:0] pc_rdata,
   output logic       latch_a,
   output logic       latch_b,
   output logic       intr_a,
   output logic       intr_b
);

   import ppi_pkg::*;

   logic [6:0] mode_q;
   logic [7:0] pc_latch_q;
   mode_t      m;
   logic       mset;
   logic       bsr;
   logic [2:0] bsr_sel;
   logic       bsr_val;
   logic       inte_a_hit;
   logic       inte_b_hit;
   logic       stb_pad_a;
   logic       ibf_a, obf_n_a, inte_a, stb_rd_a;
   logic       ibf_b, obf_n_b, inte_b, stb_rd_b;

   assign m       = mode_decode(mode_q);
   assign mset    = cw_wr & cw_data[CW_MSET];
   assign bsr     = cw_wr & ~cw_data[CW_MSET];
   assign bsr_sel = cw_data[CW_BSR_HI:CW_BSR_LO];
   assign bsr_val = cw_data[CW_BSR_VAL];

   // In mode 1 the BSR address of the strobe pin is an alias for that group's INTE flag.
   assign inte_a_hit = bsr & m.a_m1 &
                       (bsr_sel == (m.dir_a ? 3'(PC_STB_A) : 3'(PC_ACK_A)));
   assign inte_b_hit = bsr & m.b_m1 & (bsr_sel == 3'(PC_HS2_B));

   // Group A watches STB_n on PC4 when input, ACK_n on PC6 when output.
   assign stb_pad_a = m.dir_a ? pc_in[PC_STB_A] : pc_in[PC_ACK_A];

   // Mode register and port C output latch.
   always_ff @(posedge clk) begin
      if (Reset) begin
         mode_q     <= MODE_RST[6:0];
         pc_latch_q <= PC_RST;
      end else if (mset) begin
         mode_q     <= cw_data[6:0];
         pc_latch_q <= PC_RST;
      end else if (bsr && !inte_a_hit && !inte_b_hit) begin
         pc_latch_q[bsr_sel] <= bsr_val;
      end
   end

   ppi_hs_chan #(
      .SYNC_STAGES (SYNC_STAGES)
   ) u_chan_a (
      .clk       (clk),
      .Reset     (Reset),
      .clr       (mset),
      .en        (m.a_m1),
      .dir       (m.dir_a),
      .stb_pad   (stb_pad_a),
      .rd        (rd_a),
      .wr        (wr_a),
      .inte_wr   (inte_a_hit),
      .inte_val  (bsr_val),
      .ibf       (ibf_a),
      .obf_n     (obf_n_a),
      .inte      (inte_a),
      .intr      (intr_a),
      .latch     (latch_a),
      .stb_rdata (stb_rd_a)
   );

   ppi_hs_chan #(
      .SYNC_STAGES (SYNC_STAGES)
   ) u_chan_b (
      .clk       (clk),
      .Reset     (Reset),
      .clr       (mset),
      .en        (m.b_m1),
      .dir       (m.dir_b),
      .stb_pad   (pc_in[PC_HS2_B]),
      .rd        (rd_b),
      .wr        (wr_b),
      .inte_wr   (inte_b_hit),
      .inte_val  (bsr_val),
      .ibf       (ibf_b),
      .obf_n     (obf_n_b),
      .inte      (inte_b),
      .intr      (intr_b),
      .latch     (latch_b),
      .stb_rdata (stb_rd_b)
   );

   // Pin ownership: nibble direction by default, handshake pins override in mode 1.
   always_comb begin
      pc_out = pc_latch_q;
      pc_oe  = {{4{~m.dir_cu}}, {4{~m.dir_cl}}};
      if (m.a_m1) begin
         pc_oe[PC_INTR_A]  = 1'b1;
         pc_out[PC_INTR_A] = intr_a;
         if (m.dir_a) begin
            pc_oe[PC_STB_A]  = 1'b0;
            pc_oe[PC_IBF_A]  = 1'b1;
            pc_out[PC_IBF_A] = ibf_a;
         end else begin
            pc_oe[PC_ACK_A]  = 1'b0;
            pc_oe[PC_OBF_A]  = 1'b1;
            pc_out[PC_OBF_A] = obf_n_a;
         end
      end
      if (m.b_m1) begin
         pc_oe[PC_INTR_B]  = 1'b1;
         pc_out[PC_INTR_B] = intr_b;
         pc_oe[PC_HS2_B]   = 1'b0;
         pc_oe[PC_HS1_B]   = 1'b1;
         pc_out[PC_HS1_B]  = m.dir_b ? ibf_b : obf_n_b;
      end
   end

   // CPU read: driven bits return what is driven, input bits the pad; strobe pins per channel.
   always_comb begin
      pc_rdata = (pc_oe & pc_out) | (~pc_oe & pc_in);
      if (m.a_m1) begin
         if (m.dir_a) begin
            pc_rdata[PC_STB_A] = stb_rd_a;
         end else begin
            pc_rdata[PC_ACK_A] = stb_rd_a;
         end
      end
      if (m.b_m1) begin
         pc_rdata[PC_HS2_B] = stb_rd_b;
      end
   end

endmodule

// File: doc/ppi_portc_hs.md
Name: ppi_portc_hs

Overview:
- Parametrised successor to the port-C-upper block of the 8255A-style PPI.
- Owns all 8 port C bits and adds:
  - the bit set/reset (BSR) path;
  - mode-1 strobed handshakes for groups A and B (STB/IBF/ACK/OBF/INTR with INTE masks);
  - strobe synchronisers.
- Sits between the control-word decoder, the port A/B data blocks and the PC[7:0] pads.

Parameters:
- SYNC_STAGES, 2, flip-flop stages on each external strobe before edge detection (legal 1..4)
- PC_RST, 8'h00, port C output latch value after Reset and after any mode-set write

Ports:
- clk  in  1  system clock, all logic rising-edge
- Reset  in  1  synchronous, active-high reset
- cw_wr  in  1  one-cycle strobe: cw_data is a control word
- cw_data  in  8  control word; bit7=1 mode set, bit7=0 BSR
- rd_a, rd_b  in  1 each  one-cycle CPU read strobe of port A / B
- wr_a, wr_b  in  1 each  one-cycle CPU write strobe of port A / B
- pc_in  in  8  synchronous-sampled pad values of PC[7:0]
- pc_out  out  8  pad drive values
- pc_oe  out  8  per-bit output enable (1 = drive)
- pc_rdata  out  8  value returned on CPU port C read
- latch_a, latch_b  out  1 each  one-cycle pulse: port A / B input register captures pad data
- intr_a, intr_b  out  1 each  interrupt requests (copies of PC3 / PC0 in mode 1)

Behaviour:
- Mode register fields:
  - grpA_mode = cw[6:5]; only 00 and 01 are legal, 1x is treated as 01.
  - dirA = cw[4], dirCu = cw[3], grpB_mode = cw[2], dirB = cw[1], dirCl = cw[0]; direction bits: 1 = input.
- Reset:
  - mode register = 8'h9B (all inputs, mode 0).
  - pc_out = PC_RST, pc_oe = 0.
  - IBF_A/B = 0, OBF_n_A/B = 1, INTE_A/B = 0, INTR = 0, latch pulses = 0.
  - Synchroniser chains load 1 (strobes idle high).
- Mode-set write: next cycle the mode register updates, pc_out = PC_RST, and all handshake flags return to their reset values.
- BSR write (cw[7]=0): next cycle bit cw[3:1] of the output latch = cw[0]. In mode 1, the INTE flags are aliased instead:
  - group A input: PC4 -> INTE_A;
  - group A output: PC6 -> INTE_A;
  - group B: PC2 -> INTE_B.
  - A BSR write to a pin owned as a handshake output updates the latch only; the pin keeps driving the handshake signal.
- Mode 0, per nibble: pc_oe = ~dirCx; pc_out = latch.
- Mode 1 group A pin ownership: PC3 = INTR_A; input uses PC4 = STB_A_n (in) and PC5 = IBF_A (out); output uses PC7 = OBF_A_n (out) and PC6 = ACK_A_n (in). Remaining PCu bit follows dirCu.
- Mode 1 group B pin ownership: PC0 = INTR_B, PC2 = STB_n/ACK_n (in), PC1 = IBF/OBF_n (out).
- Synchroniser edge latency: a pad edge appears as fall/rise pulses SYNC_STAGES+1 cycles later.
- Input handshake:
  - STB fall -> latch_x pulse the same cycle as the fall pulse; IBF=1 the next cycle.
  - STB rise -> INTR=1 the next cycle if INTE and IBF.
  - rd_x -> IBF=0 and INTR=0 the next cycle.
  - rd_x coincident with STB fall: the set wins, IBF=1.
- Output handshake:
  - wr_x -> OBF_n=0 and INTR=0 the next cycle.
  - ACK fall -> OBF_n=1.
  - ACK rise -> INTR=1 if INTE and OBF_n=1.
  - wr_x coincident with ACK fall: wr wins, OBF_n=0.
- Edges arriving while a group is in mode 0 are ignored. Reset overrides everything.
- pc_rdata: output-direction bits return the latch value and input bits return pc_in. Exception: handshake bits, see Optional Feature.

Optional Feature:
- Macro PPI_PORTC_STATUS_EN.
- Defined: in mode 1, pc_rdata bits owned by a handshake return the internal status instead of the pad:
  - INTR, IBF and OBF_n values;
  - the INTE flag in place of the STB/ACK input bit (8255 status-word format).
- Undefined: pc_rdata returns raw pc_in for handshake input bits and the driven value for handshake output bits.

Decomposition:
- Package ppi_pkg:
  - control-word field positions;
  - mode encodings (MODE0, MODE1);
  - mode-1 pin index constants (PC_INTR_A=3, PC_STB_A=4, PC_IBF_A=5, PC_ACK_A=6, PC_OBF_A=7, PC_INTR_B=0, PC_HS1_B=1, PC_HS2_B=2);
  - reset mode word 8'h9B.
- One sub-module, ppi_hs_chan, instanced twice (A, B):
  - synchroniser and edge detect;
  - IBF/OBF/INTE/INTR flags;
  - latch pulse;
  - dir input selects input or output handshake.

Test Plan:
- Reset then BSR writes 8'h0F, 8'h0A (mode 0, write 8'h80 first) -> pc_out[7]=1 then pc_out[5]=0, pc_oe=8'hFF.
- Mode 8'hB0 (A mode1 input); INTE_A set via BSR 8'h09; drive PC4 low 3 cycles then high -> latch_a pulse at sync+1, IBF_A/PC5=1, intr_a=1 after rise; rd_a -> both 0.
- Mode 8'hA0 (A mode1 output), INTE_A via 8'h0D; wr_a -> PC7=0; ACK PC6 pulse low -> PC7=1, intr_a=1; wr_a clears intr_a.
- rd_a coincident with STB fall pulse -> IBF_A remains 1; wr_b coincident with ACK_B fall -> OBF_B_n=0.
- Mid-handshake mode-set 8'h9B or Reset asserted -> pc_out=PC_RST, intr_a=intr_b=0, IBF=0, OBF_n=1 next cycle.
- PPI_PORTC_STATUS_EN on/off: mode-1 input A, IBF set, read port C -> bit5=1, bit4=INTE_A (on) vs raw pin (off).
